// File: rtl/io_map_pkg.sv
// Register map shared by the I/O input and output paths.
package io_map_pkg;

   localparam int unsigned IO_REG_W = 5;

   localparam logic [IO_REG_W-1:0] IO_SW        = 5'h00;
   localparam logic [IO_REG_W-1:0] IO_KEY_LEVEL = 5'h01;
   localparam logic [IO_REG_W-1:0] IO_KEY_EVENT = 5'h02;
   localparam logic [IO_REG_W-1:0] IO_PRESS_CNT = 5'h03;

   typedef logic [3:0] key_vec_t;

   // Number of keys pressing on one edge, 0 to 4.
   function automatic logic [2:0] count_presses(input key_vec_t v);
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < 4; i++) begin
         n = n + {2'b00, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One push key: 2-flop synchroniser on the inverted key, stability counter and accepted level.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic io_clk,
   input  logic clrn,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync_q;
   logic             pressed_sync;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;

   assign pressed_sync = sync_q[1];

   always_ff @(posedge io_clk or negedge clrn) begin
      if (!clrn) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], ~key_n};
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   // Any return to the accepted level restarts the count.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      press   = 1'b0;
      if (pressed_sync == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         level_d = pressed_sync;
         cnt_d   = '0;
         press   = pressed_sync;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign level = level_q;

endmodule

// File: rtl/io_input_ctrl.sv
// Memory-mapped input peripheral: synchronised switches, debounced keys, sticky press events
// and a press counter, read with zero latency through io_read_data.
module io_input_ctrl
   import io_map_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned NUM_KEYS        = 4
) (
   input  logic                io_clk,
   input  logic                clrn,
   input  logic [31:0]         addr,
   input  logic                io_rd,
   input  logic [31:0]         in_port0,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [31:0]         io_read_data
);

   logic [31:0]         sw_meta_q, sw_sync_q;
   logic [NUM_KEYS-1:0] key_level, key_press;
   logic [NUM_KEYS-1:0] key_event_q, key_event_d;
   logic [15:0]         press_count_q, press_count_d;
   logic [IO_REG_W-1:0] reg_sel;
   logic                rd_clr;
   logic                unused_addr;

   assign reg_sel     = addr[6:2];
   assign unused_addr = ^{addr[31:7], addr[1:0]};

   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key_debounce (
         .io_clk(io_clk),
         .clrn  (clrn),
         .key_n (key_n[gi]),
         .level (key_level[gi]),
         .press (key_press[gi])
      );
   end

   assign rd_clr = io_rd && (reg_sel == IO_KEY_EVENT);

   // A press landing on the clearing edge survives the clear.
   always_comb begin
      key_event_d   = (key_event_q & ~{NUM_KEYS{rd_clr}}) | key_press;
      press_count_d = press_count_q + 16'(count_presses(key_vec_t'(key_press)));
   end

   always_ff @(posedge io_clk or negedge clrn) begin
      if (!clrn) begin
         sw_meta_q     <= '0;
         sw_sync_q     <= '0;
         key_event_q   <= '0;
         press_count_q <= '0;
      end else begin
         sw_meta_q     <= in_port0;
         sw_sync_q     <= sw_meta_q;
         key_event_q   <= key_event_d;
         press_count_q <= press_count_d;
      end
   end

   always_comb begin
      io_read_data = '0;
      case (reg_sel)
         IO_SW:        io_read_data = sw_sync_q;
         IO_KEY_LEVEL: io_read_data = 32'(key_level);
         IO_KEY_EVENT: io_read_data = 32'(key_event_q);
         IO_PRESS_CNT: io_read_data = {16'b0, press_count_q};
         default:      io_read_data = '0;
      endcase
   end

endmodule

// File: tb/tb_io_input_ctrl.sv
// Directed bench for io_input_ctrl with DEBOUNCE_CYCLES = 4.
module tb_io_input_ctrl;

   logic        io_clk = 1'b0;
   logic        clrn;
   logic [31:0] addr;
   logic        io_rd;
   logic [31:0] in_port0;
   logic [3:0]  key_n;
   logic [31:0] io_read_data;

   int n_checks = 0;
   int n_errors = 0;

   io_input_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .NUM_KEYS       (4)
   ) dut (
      .io_clk      (io_clk),
      .clrn        (clrn),
      .addr        (addr),
      .io_rd       (io_rd),
      .in_port0    (in_port0),
      .key_n       (key_n),
      .io_read_data(io_read_data)
   );

   always #5 io_clk = ~io_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then stop on the following falling edge.
   task automatic tick(input int n);
      repeat (n) @(posedge io_clk);
      @(negedge io_clk);
   endtask

   task automatic set_reg(input logic [4:0] idx);
      addr = {24'h0, 1'b1, idx, 2'b00};
      #1;
   endtask

   task automatic check_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
      set_reg(idx);
      check(tag, io_read_data, exp);
   endtask

   initial begin
      clrn     = 1'b0;
      addr     = 32'h80;
      io_rd    = 1'b0;
      in_port0 = 32'h0;
      key_n    = 4'hF;

      // Reset state
      tick(2);
      check_reg("rst_sw", 5'h00, 32'h0);
      check_reg("rst_level", 5'h01, 32'h0);
      check_reg("rst_event", 5'h02, 32'h0);
      check_reg("rst_count", 5'h03, 32'h0);
      clrn = 1'b1;
      tick(1);

      // Switch path latency
      set_reg(5'h00);
      in_port0 = 32'hDEADBEEF;
      tick(1);
      check("sw_edge1", io_read_data, 32'h0);
      tick(1);
      check("sw_edge2", io_read_data, 32'hDEADBEEF);
      addr = 32'hFFFF_FF80;
      #1;
      check("sw_addr_hi_ignored", io_read_data, 32'hDEADBEEF);
      check_reg("unmapped_05", 5'h05, 32'h0);
      check_reg("unmapped_1f", 5'h1F, 32'h0);

      // Clean press of key 2
      set_reg(5'h01);
      key_n = 4'b1011;
      tick(5);
      check("k2_level_edge5", io_read_data, 32'h0);
      tick(1);
      check("k2_level_edge6", io_read_data, 32'h4);
      check_reg("k2_event", 5'h02, 32'h4);
      check_reg("k2_count", 5'h03, 32'h1);
      key_n = 4'hF;
      tick(8);
      check_reg("k2_rel_level", 5'h01, 32'h0);
      check_reg("k2_rel_event", 5'h02, 32'h4);
      check_reg("k2_rel_count", 5'h03, 32'h1);

      // Read-to-clear
      set_reg(5'h02);
      io_rd = 1'b1;
      #1;
      check("clr_read", io_read_data, 32'h4);
      tick(1);
      io_rd = 1'b0;
      #1;
      check("clr_after", io_read_data, 32'h0);

      // Key 1 completes debounce on the clearing edge; back-to-back strobes
      key_n = 4'b1011;
      tick(6);
      check_reg("k2_again_event", 5'h02, 32'h4);
      key_n = 4'hF;
      tick(8);
      key_n = 4'b1101;
      tick(5);
      set_reg(5'h02);
      io_rd = 1'b1;
      #1;
      check("race_read", io_read_data, 32'h4);
      tick(1);
      check("race_set_wins", io_read_data, 32'h2);
      tick(1);
      io_rd = 1'b0;
      #1;
      check("race_second_clear", io_read_data, 32'h0);
      check_reg("race_count", 5'h03, 32'h3);
      check_reg("race_level", 5'h01, 32'h2);
      key_n = 4'hF;
      tick(8);

      // Bouncing key 0 never settles
      for (int i = 0; i < 10; i++) begin
         key_n[0] = ~key_n[0];
         tick(2);
      end
      key_n = 4'hF;
      tick(8);
      check_reg("bounce_level", 5'h01, 32'h0);
      check_reg("bounce_event", 5'h02, 32'h0);
      check_reg("bounce_count", 5'h03, 32'h3);

      // All four keys on one edge
      set_reg(5'h03);
      key_n = 4'h0;
      tick(5);
      check("all4_edge5", io_read_data, 32'h3);
      tick(1);
      check("all4_edge6", io_read_data, 32'h7);
      check_reg("all4_event", 5'h02, 32'hF);
      check_reg("all4_level", 5'h01, 32'hF);
      key_n = 4'hF;
      tick(8);
      set_reg(5'h02);
      io_rd = 1'b1;
      tick(1);
      io_rd = 1'b0;

      // Counter wrap from 0xFFFE
      force dut.press_count_q = 16'hFFFE;
      tick(1);
      release dut.press_count_q;
      tick(1);
      check_reg("preload_count", 5'h03, 32'hFFFE);
      key_n = 4'h0;
      tick(6);
      check_reg("wrap_count", 5'h03, 32'h2);
      check_reg("wrap_event", 5'h02, 32'hF);
      key_n = 4'hF;
      tick(8);

      // Reset mid-debounce with events pending
      key_n = 4'b1110;
      tick(4);
      clrn = 1'b0;
      #1;
      check_reg("midrst_sw", 5'h00, 32'h0);
      check_reg("midrst_level", 5'h01, 32'h0);
      check_reg("midrst_event", 5'h02, 32'h0);
      check_reg("midrst_count", 5'h03, 32'h0);
      tick(1);
      clrn = 1'b1;
      set_reg(5'h01);
      tick(5);
      check("post_rst_edge5", io_read_data, 32'h0);
      tick(1);
      check("post_rst_edge6", io_read_data, 32'h1);
      check_reg("post_rst_event", 5'h02, 32'h1);
      check_reg("post_rst_count", 5'h03, 32'h1);
      check_reg("post_rst_sw", 5'h00, 32'hDEADBEEF);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/io_input_ctrl.md
# io_input_ctrl

Memory-mapped input peripheral answering MEM-stage loads in the I/O space (address bit 7 set). It synchronises the 32-bit switch port and debounces four active-low push keys. It also latches key-press events in read-to-clear sticky bits and keeps a press counter. The CPU polls all of these through `io_read_data` in the same cycle as the load. It is the responder/reader counterpart of the I/O output register path that drives the hex displays.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles needed to accept a key change; legal range ≥ 2.
- `NUM_KEYS`, 4: number of push keys; fixed at 4 for this register map.

Ports:
- `io_clk`  in  1: the block's single clock, the same clock as MEM-stage memory.
- `clrn`  in  1: asynchronous, active-low reset.
- `addr`  in  32: byte address from the MEM-stage ALU result; only `addr[6:2]` is decoded.
- `io_rd`  in  1: one-cycle read strobe, driven as load & `addr[7]`.
- `in_port0`  in  32: raw switch inputs, asynchronous to `io_clk`.
- `key_n`  in  4: raw push keys, active-low, asynchronous and bouncing.
- `io_read_data`  out  32: read data, combinational from `addr` and registered state.

## Operation
- Switch path: 2-flop synchroniser per bit, giving `sw_sync`. Reset value 0.
- Key path, per key:
  - 2-flop synchroniser on `~key_n`, giving `pressed_sync`. Reset value 0 (released).
  - Counter `cnt`, width `$clog2(DEBOUNCE_CYCLES)`.
  - If `pressed_sync == key_level`: `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: `key_level <= pressed_sync` and `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - `key_level` resets to 0.
- Press event: on the edge where `key_level` goes 0→1, set `key_event[i]`. A 1→0 transition (release) sets nothing.
- Register map, selected by `addr[6:2]`:
  - 0x00: `{sw_sync}`.
  - 0x01: `{28'b0, key_level[3:0]}`.
  - 0x02: `{28'b0, key_event[3:0]}`; read-to-clear.
  - 0x03: `{16'b0, press_count[15:0]}`.
  - 0x04–0x1F: read as 0.
- `io_read_data` is driven for every address value, whether or not `io_rd` is high. It has no side effects except the KEY_EVENT clear.
- Read-to-clear: on the `io_clk` edge with `io_rd` high and `addr[6:2] == 0x02`, clear all `key_event` bits. A bit being set on that same edge stays set: set has priority over clear.
- `press_count`:
  - Adds the number of press events occurring on each edge (0–4).
  - 16-bit modulo arithmetic, so 0xFFFF + 1 = 0x0000.
  - Never cleared by reads.
- The block ignores `addr[31:8]` and `addr[1:0]`. The decoder upstream guarantees `addr[7] = 1` whenever `io_rd` is high.

## Timing
- Reset (`clrn` low, asynchronous):
  - all synchroniser flops, `key_level`, `cnt`, `key_event` and `press_count` go to 0;
  - `io_read_data` therefore reads 0 at every address.
- A reset assertion mid-debounce discards the partial count; there is no pending event after reset.
- Switch latency: a change on `in_port0` is visible at address 0x00 after the 2nd `io_clk` edge.
- Key latency: a clean, stable press becomes visible in `key_level` and `key_event` after 2 + `DEBOUNCE_CYCLES` rising edges of `io_clk`.
- Bounce handling: any return of `pressed_sync` to `key_level` before the count completes restarts the count from 0.
- Read data is valid in the same cycle as `addr` (zero latency), as the pipeline requires. A clear from a read is seen by the next read.
- Repeated strobes (for example, back-to-back loads) each clear independently. No read ever returns a bit that was already cleared.

## Structure
- Shared package `io_map_pkg`: register offset constants `IO_SW = 5'h00`, `IO_KEY_LEVEL = 5'h01`, `IO_KEY_EVENT = 5'h02`, `IO_PRESS_CNT = 5'h03`. The output-register side uses the same package.
- Sub-module `key_debounce`, instantiated 4 times:
  - contains the synchroniser, counter and `key_level`;
  - outputs `level` and a one-cycle `press` pulse.
- Top level holds the switch synchroniser, `key_event`, `press_count` and the read mux.

## Test plan
Benches use `DEBOUNCE_CYCLES` = 4.
- Reset, then set `in_port0` = 0xDEADBEEF with `addr[6:2]` = 0x00 → `io_read_data` is 0 after the 1st edge and 0xDEADBEEF after the 2nd.
- Hold `key_n[2]` low steadily → at address 0x01, reads 0x0 through edge 5 and 0x4 after edge 6. Address 0x02 reads 0x4; address 0x03 reads 1.
- Bounce `key_n[0]` low/high every 2 cycles for 20 cycles, then release → `key_level`, `key_event` and `press_count` all stay 0.
- With event 0x4 pending, pulse `io_rd` at 0x02 → that cycle reads 0x4 and the next read returns 0x0. Then repeat with `key_n[1]` completing its debounce on the same edge as the read → the next read returns 0x2.
- Press all four keys simultaneously → `press_count` += 4 on one edge. With `press_count` preloaded at 0xFFFE by 0xFFFE presses (or by a force), one more group of four → reads 0x0002.
- Assert `clrn` low mid-debounce (`cnt` = 2) and while events are pending → all registers read 0 immediately. After release, a new press requires the full 6 edges.
